// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: arbiter FSM states, CPU phase encodings and LD/ST opcodes shared with CPU decode.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_WAIT = 2'b01,
        ARB_RESP = 2'b10
    } arb_state_t;

    localparam logic [3:0] PH0 = 4'b0001;
    localparam logic [3:0] PH1 = 4'b0010;
    localparam logic [3:0] PH2 = 4'b0100;
    localparam logic [3:0] PH3 = 4'b1000;

    localparam logic [3:0] OP_LD = 4'b0010;
    localparam logic [3:0] OP_ST = 4'b0011;

    function automatic logic is_mem_op(input logic [3:0] opcode);
        return opcode == OP_LD || opcode == OP_ST;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that either saturates at all-ones or wraps.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         sat,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (en && !(sat && &count))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port data memory between the CPU (always first) and a host port.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [3:0]    ph,
    input  logic [15:0]   ir,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_write,
    output logic [DW-1:0] cpu_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    output logic [CW-1:0] host_count,
    output logic [CW-1:0] stall_count,
    output logic          host_grant
);

    arb_state_t    state, next_state;
    logic          cpu_slot;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          unused_ir;

    assign unused_ir = ^ir[11:0];
    assign cpu_slot  = cpu_write || (ph == PH2 && is_mem_op(ir[15:12]));
    assign cpu_rdata = mem_rdata;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= ARB_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state == ARB_IDLE ? (host_req ? ARB_WAIT : ARB_IDLE) :
                     state == ARB_WAIT ? (cpu_slot ? ARB_WAIT : ARB_RESP) : ARB_IDLE;
    end

    always_comb begin
        host_grant = state == ARB_WAIT && !cpu_slot;
        host_ack   = state == ARB_RESP;
        mem_addr   = host_grant ? lat_addr  : cpu_addr;
        mem_wdata  = host_grant ? lat_wdata : cpu_wdata;
        mem_write  = host_grant ? lat_we    : cpu_write;
    end

    // Host request is captured once so the host may change nothing until ack.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == ARB_IDLE && host_req) begin
            lat_we    <= host_we;
            lat_addr  <= host_addr;
            lat_wdata <= host_wdata;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            host_rdata <= '0;
        else if (host_grant && !lat_we)
            host_rdata <= mem_rdata;
    end

    sat_counter #(.W(CW)) u_host_count (
        .clk   (CLK),
        .rst   (RST),
        .en    (host_ack),
        .sat   (1'b0),
        .count (host_count)
    );

    sat_counter #(.W(CW)) u_stall_count (
        .clk   (CLK),
        .rst   (RST),
        .en    (state == ARB_WAIT && cpu_slot),
        .sat   (1'b1),
        .count (stall_count)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a small behavioural memory.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        CLK, RST;
    logic [3:0]  ph;
    logic [15:0] ir, cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_write;
    logic        host_req, host_we, host_ack, host_grant;
    logic [15:0] host_addr, host_wdata, host_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write;
    logic [15:0] host_count, stall_count;

    logic [15:0] mem [0:255];
    logic        mem_clr;
    int          vectors, miscompares;
    logic        bound_en, bound_viol;
    int          stall_run;
    logic [15:0] prev_stall;

    dmem_arbiter #(.AW(16), .DW(16), .CW(16)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ph          (ph),
        .ir          (ir),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_write   (cpu_write),
        .cpu_rdata   (cpu_rdata),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ack    (host_ack),
        .host_rdata  (host_rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_write   (mem_write),
        .mem_rdata   (mem_rdata),
        .host_count  (host_count),
        .stall_count (stall_count),
        .host_grant  (host_grant)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge CLK) begin
        if (mem_clr)
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0;
        else if (mem_write)
            mem[mem_addr[7:0]] <= mem_wdata;
    end

    // A host transaction may be stalled by at most one consecutive CPU slot.
    always @(negedge CLK) begin
        if (bound_en && stall_count == prev_stall + 16'd1)
            stall_run = stall_run + 1;
        else
            stall_run = 0;
        if (stall_run > 1) bound_viol = 1'b1;
        prev_stall = stall_count;
    end

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic host_xact(input logic we, input logic [15:0] a, input logic [15:0] d,
                             input int stalls, input logic [15:0] sir, input logic swr,
                             output int n, output int hw, output int cw,
                             output logic [15:0] hwa, output logic clash);
        n = 0; hw = 0; cw = 0; hwa = '0; clash = 1'b0;
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        @(posedge CLK); #1;
        n = 1;
        while (!host_ack && n < 10) begin
            ph        = n <= stalls ? PH2 : 4'b0;
            ir        = n <= stalls ? sir : 16'h0;
            cpu_addr  = 16'h0020;
            cpu_wdata = 16'h1234;
            cpu_write = n <= stalls ? swr : 1'b0;
            #1;
            if (mem_write && host_grant) begin hw++; hwa = mem_addr; end
            if (mem_write && !host_grant) cw++;
            if (host_grant && n <= stalls) clash = 1'b1;
            @(posedge CLK); #1;
            n++;
        end
        host_req = 1'b0; ph = 4'b0; ir = 16'h0; cpu_write = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        cpu_addr = 16'h0077; #1;
        vectors++; if (host_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack got %h want 0", host_ack); end
        vectors++; if (host_grant !== 1'b0) begin miscompares++; $display("FAIL reset_grant got %h want 0", host_grant); end
        vectors++; if (host_count !== 16'h0) begin miscompares++; $display("FAIL reset_host_count got %h want 0000", host_count); end
        vectors++; if (stall_count !== 16'h0) begin miscompares++; $display("FAIL reset_stall_count got %h want 0000", stall_count); end
        vectors++; if (host_rdata !== 16'h0) begin miscompares++; $display("FAIL reset_rdata got %h want 0000", host_rdata); end
        vectors++; if (mem_addr !== 16'h0077) begin miscompares++; $display("FAIL reset_mux got %h want 0077", mem_addr); end
        vectors++; if (mem_write !== 1'b0) begin miscompares++; $display("FAIL reset_mem_write got %h want 0", mem_write); end
    endtask

    task automatic test_host_write();
        int n, hw, cw; logic [15:0] hwa; logic clash;
        host_xact(1'b1, 16'h0010, 16'hBEEF, 0, 16'h0, 1'b0, n, hw, cw, hwa, clash);
        vectors++; if (n !== 2) begin miscompares++; $display("FAIL wr_latency got %0d want 2", n); end
        vectors++; if (hw !== 1) begin miscompares++; $display("FAIL wr_pulses got %0d want 1", hw); end
        vectors++; if (hwa !== 16'h0010) begin miscompares++; $display("FAIL wr_addr got %h want 0010", hwa); end
        vectors++; if (mem[16] !== 16'hBEEF) begin miscompares++; $display("FAIL wr_mem got %h want beef", mem[16]); end
        vectors++; if (host_ack !== 1'b0) begin miscompares++; $display("FAIL wr_ack_width got %h want 0", host_ack); end
        vectors++; if (host_count !== 16'd1) begin miscompares++; $display("FAIL wr_host_count got %h want 0001", host_count); end
        vectors++; if (stall_count !== 16'd0) begin miscompares++; $display("FAIL wr_stall_count got %h want 0000", stall_count); end
    endtask

    task automatic test_host_read();
        int n, hw, cw; logic [15:0] hwa; logic clash;
        host_xact(1'b0, 16'h0010, 16'h0000, 0, 16'h0, 1'b0, n, hw, cw, hwa, clash);
        vectors++; if (n !== 2) begin miscompares++; $display("FAIL rd_latency got %0d want 2", n); end
        vectors++; if (hw !== 0) begin miscompares++; $display("FAIL rd_no_write got %0d want 0", hw); end
        vectors++; if (host_rdata !== 16'hBEEF) begin miscompares++; $display("FAIL rd_data got %h want beef", host_rdata); end
        repeat (3) @(posedge CLK); #1;
        vectors++; if (host_rdata !== 16'hBEEF) begin miscompares++; $display("FAIL rd_hold got %h want beef", host_rdata); end
        vectors++; if (host_count !== 16'd2) begin miscompares++; $display("FAIL rd_host_count got %h want 0002", host_count); end
    endtask

    task automatic test_contention();
        int n, hw, cw; logic [15:0] hwa; logic clash;
        host_xact(1'b1, 16'h0030, 16'hCAFE, 1, {OP_ST, 12'h0}, 1'b1, n, hw, cw, hwa, clash);
        vectors++; if (n !== 3) begin miscompares++; $display("FAIL st_latency got %0d want 3", n); end
        vectors++; if (cw !== 1) begin miscompares++; $display("FAIL st_cpu_writes got %0d want 1", cw); end
        vectors++; if (hw !== 1) begin miscompares++; $display("FAIL st_host_writes got %0d want 1", hw); end
        vectors++; if (clash !== 1'b0) begin miscompares++; $display("FAIL st_grant_clash got %h want 0", clash); end
        vectors++; if (mem[32] !== 16'h1234) begin miscompares++; $display("FAIL st_cpu_mem got %h want 1234", mem[32]); end
        vectors++; if (mem[48] !== 16'hCAFE) begin miscompares++; $display("FAIL st_host_mem got %h want cafe", mem[48]); end
        vectors++; if (stall_count !== 16'd1) begin miscompares++; $display("FAIL st_stall_count got %h want 0001", stall_count); end
        cpu_addr = 16'h0020; #1;
        vectors++; if (cpu_rdata !== 16'h1234) begin miscompares++; $display("FAIL cpu_rdata got %h want 1234", cpu_rdata); end
    endtask

    task automatic test_decode();
        int n, hw, cw; logic [15:0] hwa; logic clash;
        host_xact(1'b0, 16'h0030, 16'h0000, 1, {OP_LD, 12'hABC}, 1'b0, n, hw, cw, hwa, clash);
        vectors++; if (n !== 3) begin miscompares++; $display("FAIL ld_latency got %0d want 3", n); end
        vectors++; if (clash !== 1'b0) begin miscompares++; $display("FAIL ld_grant_clash got %h want 0", clash); end
        vectors++; if (stall_count !== 16'd2) begin miscompares++; $display("FAIL ld_stall_count got %h want 0002", stall_count); end
        vectors++; if (host_rdata !== 16'hCAFE) begin miscompares++; $display("FAIL ld_rdata got %h want cafe", host_rdata); end
        host_xact(1'b0, 16'h0010, 16'h0000, 1, 16'h1000, 1'b0, n, hw, cw, hwa, clash);
        vectors++; if (n !== 2) begin miscompares++; $display("FAIL add_latency got %0d want 2", n); end
        vectors++; if (stall_count !== 16'd2) begin miscompares++; $display("FAIL add_stall_count got %h want 0002", stall_count); end
        vectors++; if (host_count !== 16'd5) begin miscompares++; $display("FAIL dec_host_count got %h want 0005", host_count); end
    endtask

    task automatic test_reset_in_wait();
        int acks;
        acks = 0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0050; host_wdata = 16'hDEAD;
        @(posedge CLK); #1;
        vectors++; if (host_grant !== 1'b1) begin miscompares++; $display("FAIL rw_grant_before got %h want 1", host_grant); end
        RST = 1'b1; #1;
        vectors++; if (host_grant !== 1'b0 || mem_write !== 1'b0) begin miscompares++; $display("FAIL rw_mux got grant %h write %h want 0 0", host_grant, mem_write); end
        host_req = 1'b0;
        repeat (2) @(posedge CLK); #1;
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (host_ack) acks++;
            @(posedge CLK); #1;
        end
        vectors++; if (acks !== 0) begin miscompares++; $display("FAIL rw_acks got %0d want 0", acks); end
        vectors++; if (mem[80] !== 16'h0) begin miscompares++; $display("FAIL rw_mem got %h want 0000", mem[80]); end
        vectors++; if (host_count !== 16'h0 || stall_count !== 16'h0) begin miscompares++; $display("FAIL rw_counts got %h %h want 0000 0000", host_count, stall_count); end
        vectors++; if (host_rdata !== 16'h0) begin miscompares++; $display("FAIL rw_rdata got %h want 0000", host_rdata); end
    endtask

    task automatic test_back_to_back();
        int acks, width, max_width;
        logic prev;
        acks = 0; width = 0; max_width = 0; prev = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0040; host_wdata = 16'h5555;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            if (host_ack) begin
                if (!prev) acks++;
                width++;
                if (width > max_width) max_width = width;
                if (acks == 2) host_req = 1'b0;
            end else width = 0;
            prev = host_ack;
        end
        vectors++; if (acks !== 2) begin miscompares++; $display("FAIL b2b_acks got %0d want 2", acks); end
        vectors++; if (max_width !== 1) begin miscompares++; $display("FAIL b2b_ack_width got %0d want 1", max_width); end
        vectors++; if (host_count !== 16'd2) begin miscompares++; $display("FAIL b2b_host_count got %h want 0002", host_count); end
        vectors++; if (mem[64] !== 16'h5555) begin miscompares++; $display("FAIL b2b_mem got %h want 5555", mem[64]); end
    endtask

    task automatic test_saturation();
        int n;
        bound_en = 1'b0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0000;
        cpu_write = 1'b1; cpu_addr = 16'h0060; cpu_wdata = 16'h0000;
        @(posedge CLK); #1;
        repeat (65535) @(posedge CLK);
        #1;
        vectors++; if (stall_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_reach got %h want ffff", stall_count); end
        @(posedge CLK); #1;
        vectors++; if (stall_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold got %h want ffff", stall_count); end
        cpu_write = 1'b0;
        n = 0;
        while (!host_ack && n < 5) begin @(posedge CLK); #1; n++; end
        host_req = 1'b0;
        vectors++; if (n !== 1) begin miscompares++; $display("FAIL sat_release got %0d want 1", n); end
        @(posedge CLK); #1;
        bound_en = 1'b1;
    endtask

    task automatic test_stall_bound();
        vectors++; if (bound_viol !== 1'b0) begin miscompares++; $display("FAIL stall_bound got %h want 0", bound_viol); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        bound_en = 1'b1; bound_viol = 1'b0; stall_run = 0; prev_stall = 16'h0;
        ph = 4'b0; ir = 16'h0; cpu_addr = 16'h0; cpu_wdata = 16'h0; cpu_write = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = 16'h0; host_wdata = 16'h0;
        mem_clr = 1'b1;
        do_reset();
        mem_clr = 1'b0;
        test_reset();
        test_host_write();
        test_host_read();
        test_contention();
        test_decode();
        test_reset_in_wait();
        test_back_to_back();
        test_stall_bound();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the CPU datapath and a host/debug port. The host port lets a loader or debugger read and write data memory while the CPU runs.
- Sits between the CPU's dmem_* signals and the memory macro.
- The CPU cannot stall, so it always has priority. The host is served in any cycle the CPU is not using memory, through a req/ack handshake.
- Also keeps host-transaction and stall statistics for the LED/debug bus.

Parameters:
- AW, 16, address width
- DW, 16, data width
- CW, 16, width of statistics counters

Ports:
- CLK  in  1  system clock; all state updates on its rising edge
- RST  in  1  asynchronous reset, active-high
- ph  in  4  CPU phase from the phase state machine (one-hot, shared PH* defines)
- ir  in  16  CPU instruction register
- cpu_addr  in  AW  CPU data address (sr1)
- cpu_wdata  in  DW  CPU store data (sr2)
- cpu_write  in  1  CPU store strobe
- cpu_rdata  out  DW  read data to CPU dr register
- host_req  in  1  host request, level
- host_we  in  1  host write(1)/read(0), sampled with host_req
- host_addr  in  AW  host address, sampled with host_req
- host_wdata  in  DW  host write data, sampled with host_req
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  DW  registered host read data
- mem_addr  out  AW  to memory
- mem_wdata  out  DW  to memory
- mem_write  out  1  to memory
- mem_rdata  in  DW  from memory; combinational (asynchronous) read
- host_count  out  CW  completed host transactions
- stall_count  out  CW  cycles the host waited because of the CPU
- host_grant  out  1  memory owned by host this cycle

Behaviour:
- cpu_slot (combinational) = 1 when either holds:
  - ph == PH2 and ir decodes as LD or ST (shared defines);
  - cpu_write == 1 (this overrides any phase value).
- FSM states: IDLE, WAIT, RESP. State encoding lives in the package.
- IDLE:
  - If host_req == 1 at the clock edge: latch host_we, host_addr and host_wdata into internal regs, then go to WAIT.
  - Otherwise stay in IDLE.
- WAIT, cpu_slot == 1:
  - Stay in WAIT; the CPU owns memory.
  - stall_count increments; it saturates at all-ones and does not wrap.
- WAIT, cpu_slot == 0:
  - host_grant = 1.
  - mem_addr = latched address; mem_wdata = latched data; mem_write = latched we.
  - If not a write, host_rdata <= mem_rdata at the edge; on writes host_rdata holds its value.
  - Go to RESP.
- RESP:
  - host_ack = 1 for exactly one cycle.
  - host_count increments and wraps.
  - Go to IDLE.
- Host protocol:
  - The host holds req/we/addr/wdata stable until it sees ack.
  - req is sampled only in IDLE. If req is still high in the IDLE cycle after RESP, a new transaction starts (back-to-back).
- Latency: ack rises 2 cycles after the sampling edge with no contention, 3 cycles if one CPU slot intervenes.
- Bound: at most 1 CPU memory cycle per instruction, so WAIT lasts at most 1 stall cycle in normal operation. The bench must assert this bound.
- Mux when host_grant == 0: mem_addr = cpu_addr, mem_wdata = cpu_wdata, mem_write = cpu_write.
- cpu_rdata = mem_rdata always (combinational pass-through).
- host_grant and cpu_slot are never both 1.
- Reset (async, including mid-transaction):
  - FSM returns to IDLE.
  - host_ack = 0, host_grant = 0.
  - host_rdata, latched regs, host_count and stall_count are 0.
  - Memory mux reverts to CPU.
  - A transaction interrupted by reset is dropped: no ack and no write.
- With ph all zero (CPU stopped), cpu_slot = 0 unless cpu_write is set, so the host gets full bandwidth.

Decomposition:
- Shared package/defines file holds:
  - FSM state encodings (ARB_IDLE, ARB_WAIT, ARB_RESP);
  - the PH* phase encodings;
  - the LD/ST opcode patterns, already defined for CPU decode.
- One natural sub-module: sat_counter (CW-bit, increment enable, saturate-or-wrap select). Instantiate it twice, for host_count (wrap) and stall_count (saturate).

Test Plan:
- Reset, then host write addr 0x0010 data 0xBEEF with ph = 0 -> mem_write=1 for exactly 1 cycle with mem_addr=0x0010; ack 2 cycles after the sampling edge; host_count=1, stall_count=0.
- Host read of 0x0010 -> host_rdata=0xBEEF at ack; host_rdata holds after req drops.
- Host req arriving in WAIT while ph=PH2 with an ST in ir (cpu_addr 0x0020, data 0x1234) -> CPU write occurs first with host_grant=0; host access in the next cycle; stall_count=1; ack 3 cycles after the sampling edge.
- Host req held high across ack -> two back-to-back transactions; host_count=2; ack pulses are never more than 1 cycle wide.
- RST asserted while in WAIT -> host_ack never asserts; no host write reaches memory; all counters read 0.
- 65535 forced stalls followed by one more -> stall_count saturates at 0xFFFF.
